// File: rtl/sys_bridge_ctrl_pkg.sv
// Shared definitions for the processor-to-device bridge: FSM encoding,
// device indices and the default memory map.
package sys_bridge_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } bridge_state_t;

   localparam int NUM_DEV = 3;
   localparam int DEV_T0  = 0;
   localparam int DEV_T1  = 1;
   localparam int DEV_EXT = 2;

   localparam logic [31:0] DEF_T0_BASE    = 32'h0000_7F00;
   localparam logic [31:0] DEF_T1_BASE    = 32'h0000_7F10;
   localparam logic [31:0] DEF_D2_BASE    = 32'h0000_7F20;
   localparam logic [31:0] DEF_D2_SIZE    = 32'd32;
   localparam logic [31:0] TIMER_WIN_SIZE = 32'd12;
   localparam logic [31:0] DEV_SPACE_BASE = 32'h0000_7F00;

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder: one-hot window select, device-space miss
// and byte offset relative to the matched window base.
module bridge_addr_decode
   import sys_bridge_ctrl_pkg::*;
#(
   parameter logic [31:0] T0_BASE = DEF_T0_BASE,
   parameter logic [31:0] T1_BASE = DEF_T1_BASE,
   parameter logic [31:0] D2_BASE = DEF_D2_BASE,
   parameter logic [31:0] D2_SIZE = DEF_D2_SIZE
) (
   input  logic [31:0] addr,
   output logic        hit,
   output logic [2:0]  sel,
   output logic        miss,
   output logic [31:0] offset
);

   localparam logic [31:0] BASE [NUM_DEV] = '{T0_BASE, T1_BASE, D2_BASE};
   localparam logic [31:0] SIZE [NUM_DEV] = '{TIMER_WIN_SIZE, TIMER_WIN_SIZE, D2_SIZE};

   logic [31:0] diff_w [NUM_DEV];
   logic        in_space;

   // Unsigned wrap makes addr < base produce a huge diff, so one compare
   // covers both window bounds.
   generate
      for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_win
         assign diff_w[gi] = addr - BASE[gi];
         assign sel[gi]    = (diff_w[gi] < SIZE[gi]);
      end
   endgenerate

   always_comb begin
      offset = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (sel[i]) begin
            offset = offset | diff_w[i];
         end
      end
   end

   assign hit      = |sel;
   assign in_space = (addr[31:8] == DEV_SPACE_BASE[31:8]);
   assign miss     = in_space & ~hit;

endmodule

// File: rtl/sys_bridge_ctrl.sv
// MEM-stage bridge to timer0/timer1/external device: one outstanding
// request/ack transaction, pipeline stall, timeout bus error, HWInt register.
module sys_bridge_ctrl
   import sys_bridge_ctrl_pkg::*;
#(
   parameter logic [31:0] T0_BASE = DEF_T0_BASE,
   parameter logic [31:0] T1_BASE = DEF_T1_BASE,
   parameter logic [31:0] D2_BASE = DEF_D2_BASE,
   parameter logic [31:0] D2_SIZE = DEF_D2_SIZE,
   parameter int          TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PrAddr,
   input  logic [31:0] PrWD,
   input  logic [3:0]  PrBE,
   input  logic        PrWE,
   input  logic        PrRE,
   input  logic        flush,
   output logic [31:0] PrRD,
   output logic        stall,
   output logic        bus_err,
   output logic [31:0] DEV_Addr,
   output logic [31:0] DEV_WD,
   output logic [3:0]  DEV_BE,
   output logic        DEV_WE,
   output logic [2:0]  DEV_REQ,
   input  logic [2:0]  DEV_ACK,
   input  logic [31:0] DEV_RD0,
   input  logic [31:0] DEV_RD1,
   input  logic [31:0] DEV_RD2,
   input  logic [2:0]  DEV_IRQ,
   input  logic [2:0]  EXT_IRQ,
   output logic [5:0]  HWInt
);

   localparam int              CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   bridge_state_t     state_reg;
   logic [2:0]        sel_reg;
   logic [2:0]        dev_req_reg;
   logic [31:0]       addr_reg;
   logic [31:0]       wd_reg;
   logic [3:0]        be_reg;
   logic              we_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              tmo_reg;
   logic [31:0]       rd_reg;
   logic [5:0]        hwint_reg;

   logic              dec_hit;
   logic [2:0]        dec_sel;
   logic              dec_miss;
   logic [31:0]       dec_offset;

   logic              req;
   logic              issue;
   logic              ack_hit;
   logic              timeout;
   logic [31:0]       rd_mux;

   bridge_addr_decode #(
      .T0_BASE (T0_BASE),
      .T1_BASE (T1_BASE),
      .D2_BASE (D2_BASE),
      .D2_SIZE (D2_SIZE)
   ) u_decode (
      .addr   (PrAddr),
      .hit    (dec_hit),
      .sel    (dec_sel),
      .miss   (dec_miss),
      .offset (dec_offset)
   );

   assign req     = (PrWE | PrRE) & ~flush;
   assign issue   = (state_reg == IDLE) & req & dec_hit;
   assign ack_hit = |(DEV_ACK & sel_reg);
   assign timeout = (cnt_reg == CNT_MAX);

   always_comb begin
      rd_mux = '0;
      if (sel_reg[DEV_T0])  rd_mux = rd_mux | DEV_RD0;
      if (sel_reg[DEV_T1])  rd_mux = rd_mux | DEV_RD1;
      if (sel_reg[DEV_EXT]) rd_mux = rd_mux | DEV_RD2;
   end

   // Stall must rise in the issue cycle itself, before the state register moves.
   assign stall   = issue | (state_reg == WAIT);
   assign bus_err = ((state_reg == IDLE) & req & dec_miss) |
                    ((state_reg == DONE) & tmo_reg);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         sel_reg     <= '0;
         dev_req_reg <= '0;
         addr_reg    <= '0;
         wd_reg      <= '0;
         be_reg      <= '0;
         we_reg      <= 1'b0;
         cnt_reg     <= '0;
         tmo_reg     <= 1'b0;
         rd_reg      <= '0;
         hwint_reg   <= '0;
      end else begin
         hwint_reg <= {EXT_IRQ, DEV_IRQ};
         case (state_reg)
            IDLE: begin
               if (issue) begin
                  sel_reg     <= dec_sel;
                  dev_req_reg <= dec_sel;
                  addr_reg    <= dec_offset;
                  wd_reg      <= PrWD;
                  be_reg      <= PrBE;
                  we_reg      <= PrWE;
                  cnt_reg     <= '0;
                  tmo_reg     <= 1'b0;
                  state_reg   <= WAIT;
               end
            end
            WAIT: begin
               // An ack arriving on the timeout cycle still counts as success.
               if (ack_hit) begin
                  rd_reg      <= we_reg ? 32'd0 : rd_mux;
                  dev_req_reg <= '0;
                  state_reg   <= DONE;
               end else if (timeout) begin
                  rd_reg      <= '0;
                  tmo_reg     <= 1'b1;
                  dev_req_reg <= '0;
                  state_reg   <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            DONE: begin
               tmo_reg   <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign PrRD     = rd_reg;
   assign DEV_Addr = addr_reg;
   assign DEV_WD   = wd_reg;
   assign DEV_BE   = be_reg;
   assign DEV_WE   = we_reg;
   assign DEV_REQ  = dev_req_reg;
   assign HWInt    = hwint_reg;

endmodule

// File: tb/tb_sys_bridge_ctrl.sv
// Directed bench for sys_bridge_ctrl: reads, writes, misses, timeout, flush,
// reset mid-transaction and interrupt registering.
module tb_sys_bridge_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] PrAddr;
   logic [31:0] PrWD;
   logic [3:0]  PrBE;
   logic        PrWE;
   logic        PrRE;
   logic        flush;
   logic [31:0] PrRD;
   logic        stall;
   logic        bus_err;
   logic [31:0] DEV_Addr;
   logic [31:0] DEV_WD;
   logic [3:0]  DEV_BE;
   logic        DEV_WE;
   logic [2:0]  DEV_REQ;
   logic [2:0]  DEV_ACK;
   logic [31:0] DEV_RD0;
   logic [31:0] DEV_RD1;
   logic [31:0] DEV_RD2;
   logic [2:0]  DEV_IRQ;
   logic [2:0]  EXT_IRQ;
   logic [5:0]  HWInt;

   int n_cmp = 0;
   int n_err = 0;

   sys_bridge_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .PrAddr   (PrAddr),
      .PrWD     (PrWD),
      .PrBE     (PrBE),
      .PrWE     (PrWE),
      .PrRE     (PrRE),
      .flush    (flush),
      .PrRD     (PrRD),
      .stall    (stall),
      .bus_err  (bus_err),
      .DEV_Addr (DEV_Addr),
      .DEV_WD   (DEV_WD),
      .DEV_BE   (DEV_BE),
      .DEV_WE   (DEV_WE),
      .DEV_REQ  (DEV_REQ),
      .DEV_ACK  (DEV_ACK),
      .DEV_RD0  (DEV_RD0),
      .DEV_RD1  (DEV_RD1),
      .DEV_RD2  (DEV_RD2),
      .DEV_IRQ  (DEV_IRQ),
      .EXT_IRQ  (EXT_IRQ),
      .HWInt    (HWInt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      DEV_IRQ = 3'b011;
      EXT_IRQ = 3'b100;
      cyc();
      cyc();
      #1;
      n_cmp++; if (DEV_REQ !== 3'b000) begin n_err++; $display("FAIL reset_dev_req: got %b want %b", DEV_REQ, 3'b000); end
      n_cmp++; if (PrRD !== 32'd0) begin n_err++; $display("FAIL reset_prrd: got %h want %h", PrRD, 32'd0); end
      n_cmp++; if (HWInt !== 6'd0) begin n_err++; $display("FAIL reset_hwint: got %b want %b", HWInt, 6'd0); end
      n_cmp++; if (stall !== 1'b0 || bus_err !== 1'b0) begin n_err++; $display("FAIL reset_stall_err: got %b/%b want 0/0", stall, bus_err); end
      DEV_IRQ = 3'b000;
      EXT_IRQ = 3'b000;
      reset   = 1'b0;
      cyc();
      cyc();
      $display("reset: outputs checked");
   endtask

   task automatic test_load_t0();
      int stall_cnt;
      stall_cnt = 0;
      PrAddr = 32'h0000_7F04;
      PrRE   = 1'b1;
      #1;
      if (stall === 1'b1) stall_cnt++;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_issue_stall: got %b want 1", stall); end
      n_cmp++; if (DEV_REQ !== 3'b000) begin n_err++; $display("FAIL load_issue_req: got %b want 000", DEV_REQ); end
      cyc();
      DEV_ACK = 3'b010;
      DEV_RD1 = 32'hBAD0_BAD0;
      #1;
      if (stall === 1'b1) stall_cnt++;
      n_cmp++; if (DEV_REQ !== 3'b001) begin n_err++; $display("FAIL load_dev_req: got %b want 001", DEV_REQ); end
      n_cmp++; if (DEV_Addr !== 32'd4) begin n_err++; $display("FAIL load_dev_addr: got %h want %h", DEV_Addr, 32'd4); end
      cyc();
      DEV_ACK = 3'b000;
      #1;
      if (stall === 1'b1) stall_cnt++;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL load_stray_ack: stall got %b want 1", stall); end
      cyc();
      DEV_ACK = 3'b001;
      DEV_RD0 = 32'h0000_1234;
      #1;
      if (stall === 1'b1) stall_cnt++;
      cyc();
      DEV_ACK = 3'b000;
      #1;
      if (stall === 1'b1) stall_cnt++;
      n_cmp++; if (stall_cnt != 4) begin n_err++; $display("FAIL load_stall_cycles: got %0d want 4", stall_cnt); end
      n_cmp++; if (PrRD !== 32'h0000_1234) begin n_err++; $display("FAIL load_prrd: got %h want %h", PrRD, 32'h0000_1234); end
      n_cmp++; if (bus_err !== 1'b0 || DEV_REQ !== 3'b000) begin n_err++; $display("FAIL load_done: err %b req %b want 0 000", bus_err, DEV_REQ); end
      PrRE = 1'b0;
      cyc();
      $display("load 0x7f04: rd=%h stall_cycles=%0d", PrRD, stall_cnt);
   endtask

   task automatic test_timeout();
      int n;
      int err_in_wait;
      int req_bad;
      n = 0;
      err_in_wait = 0;
      req_bad = 0;
      PrAddr = 32'h0000_7F10;
      PrRE   = 1'b1;
      #1;
      while (stall === 1'b1 && n < 40) begin
         n++;
         if (bus_err !== 1'b0) err_in_wait++;
         if (n >= 2 && (DEV_REQ !== 3'b010 || DEV_Addr !== 32'd0)) req_bad++;
         cyc();
         #1;
      end
      n_cmp++; if (n >= 40) begin n_err++; $display("FAIL timeout_bound: stall still %b after %0d cycles", stall, n); end
      n_cmp++; if (n != 17) begin n_err++; $display("FAIL timeout_stall_cycles: got %0d want 17", n); end
      n_cmp++; if (err_in_wait != 0 || req_bad != 0) begin n_err++; $display("FAIL timeout_wait: err_cycles %0d req_bad %0d want 0 0", err_in_wait, req_bad); end
      n_cmp++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL timeout_bus_err: got %b want 1", bus_err); end
      n_cmp++; if (PrRD !== 32'd0) begin n_err++; $display("FAIL timeout_prrd: got %h want 0", PrRD); end
      n_cmp++; if (DEV_REQ !== 3'b000) begin n_err++; $display("FAIL timeout_req_drop: got %b want 000", DEV_REQ); end
      PrRE = 1'b0;
      cyc();
      #1;
      n_cmp++; if (bus_err !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL timeout_pulse_end: err %b stall %b want 0 0", bus_err, stall); end
      $display("load 0x7f10 timeout: stall_cycles=%0d", n);
   endtask

   task automatic test_ack_at_timeout();
      int bad;
      bad = 0;
      PrAddr  = 32'h0000_7F08;
      PrRE    = 1'b1;
      DEV_RD0 = 32'hA5A5_0001;
      #1;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         DEV_ACK = (k == 16) ? 3'b001 : 3'b000;
         #1;
         if (stall !== 1'b1) bad++;
      end
      cyc();
      DEV_ACK = 3'b000;
      #1;
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL acktmo_wait_stall: %0d cycles without stall, want 0", bad); end
      n_cmp++; if (bus_err !== 1'b0 || stall !== 1'b0) begin n_err++; $display("FAIL acktmo_done: err %b stall %b want 0 0", bus_err, stall); end
      n_cmp++; if (PrRD !== 32'hA5A5_0001) begin n_err++; $display("FAIL acktmo_prrd: got %h want %h", PrRD, 32'hA5A5_0001); end
      PrRE = 1'b0;
      cyc();
      $display("load 0x7f08 ack on last cycle: rd=%h", PrRD);
   endtask

   task automatic test_miss();
      logic [31:0] addrs [6] = '{32'h0000_7F0C, 32'h0000_7F1C, 32'h0000_7F40, 32'h0000_7FFC, 32'h0000_1000, 32'h0000_8000};
      logic        exp_err [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic        use_we [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 6; i++) begin
         PrAddr = addrs[i];
         PrWE   = use_we[i];
         PrRE   = ~use_we[i];
         #1;
         n_cmp++; if (bus_err !== exp_err[i]) begin n_err++; $display("FAIL miss_err[%0d]: got %b want %b", i, bus_err, exp_err[i]); end
         n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL miss_stall[%0d]: got %b want 0", i, stall); end
         cyc();
         PrWE = 1'b0;
         PrRE = 1'b0;
         #1;
         n_cmp++; if (DEV_REQ !== 3'b000) begin n_err++; $display("FAIL miss_req[%0d]: got %b want 000", i, DEV_REQ); end
         $display("access %h: bus_err expected %b", addrs[i], exp_err[i]);
         cyc();
      end
   endtask

   task automatic test_window_edges();
      logic [31:0] addrs [5] = '{32'h0000_7F00, 32'h0000_7F0B, 32'h0000_7F1B, 32'h0000_7F20, 32'h0000_7F3F};
      logic [2:0]  exp_req [5] = '{3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
      logic [31:0] exp_off [5] = '{32'h0, 32'hB, 32'hB, 32'h0, 32'h1F};
      logic [31:0] exp_rd;
      for (int i = 0; i < 5; i++) begin
         DEV_RD0 = 32'h1111_0000 + i;
         DEV_RD1 = 32'h2222_0000 + i;
         DEV_RD2 = 32'h3333_0000 + i;
         exp_rd  = (exp_req[i] == 3'b001) ? DEV_RD0 : (exp_req[i] == 3'b010) ? DEV_RD1 : DEV_RD2;
         PrAddr  = addrs[i];
         PrRE    = 1'b1;
         #1;
         cyc();
         DEV_ACK = exp_req[i];
         #1;
         n_cmp++; if (DEV_REQ !== exp_req[i]) begin n_err++; $display("FAIL edge_req[%0d]: got %b want %b", i, DEV_REQ, exp_req[i]); end
         n_cmp++; if (DEV_Addr !== exp_off[i]) begin n_err++; $display("FAIL edge_off[%0d]: got %h want %h", i, DEV_Addr, exp_off[i]); end
         cyc();
         DEV_ACK = 3'b000;
         PrRE    = 1'b0;
         #1;
         n_cmp++; if (PrRD !== exp_rd || stall !== 1'b0) begin n_err++; $display("FAIL edge_done[%0d]: rd %h stall %b want %h 0", i, PrRD, stall, exp_rd); end
         $display("load %h: req=%b off=%h rd=%h", addrs[i], DEV_REQ, DEV_Addr, PrRD);
         cyc();
      end
   endtask

   task automatic test_store_ext();
      PrAddr = 32'h0000_7F28;
      PrWD   = 32'hDEAD_BEEF;
      PrBE   = 4'b1111;
      PrWE   = 1'b1;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL store_issue_stall: got %b want 1", stall); end
      cyc();
      PrWD    = 32'h0000_0000;
      PrBE    = 4'b0000;
      DEV_ACK = 3'b100;
      DEV_RD2 = 32'h5555_5555;
      #1;
      n_cmp++; if (DEV_REQ !== 3'b100) begin n_err++; $display("FAIL store_req: got %b want 100", DEV_REQ); end
      n_cmp++; if (DEV_Addr !== 32'd8) begin n_err++; $display("FAIL store_addr: got %h want %h", DEV_Addr, 32'd8); end
      n_cmp++; if (DEV_WE !== 1'b1 || DEV_BE !== 4'b1111) begin n_err++; $display("FAIL store_we_be: got %b %b want 1 1111", DEV_WE, DEV_BE); end
      n_cmp++; if (DEV_WD !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_wd: got %h want %h", DEV_WD, 32'hDEAD_BEEF); end
      cyc();
      DEV_ACK = 3'b000;
      #1;
      n_cmp++; if (stall !== 1'b0 || DEV_REQ !== 3'b000) begin n_err++; $display("FAIL store_done: stall %b req %b want 0 000", stall, DEV_REQ); end
      n_cmp++; if (PrRD !== 32'd0) begin n_err++; $display("FAIL store_prrd: got %h want 0", PrRD); end
      cyc();
      PrWE = 1'b0;
      #1;
      n_cmp++; if (stall !== 1'b0 || DEV_REQ !== 3'b000) begin n_err++; $display("FAIL store_idle: stall %b req %b want 0 000", stall, DEV_REQ); end
      cyc();
      $display("store 0x7f28: wd=%h be=%b", DEV_WD, DEV_BE);
   endtask

   task automatic test_flush();
      PrAddr = 32'h0000_7F00;
      PrWE   = 1'b1;
      flush  = 1'b1;
      #1;
      n_cmp++; if (stall !== 1'b0 || bus_err !== 1'b0) begin n_err++; $display("FAIL flush_idle: stall %b err %b want 0 0", stall, bus_err); end
      cyc();
      PrAddr = 32'h0000_7F0C;
      #1;
      n_cmp++; if (DEV_REQ !== 3'b000) begin n_err++; $display("FAIL flush_no_issue: req %b want 000", DEV_REQ); end
      n_cmp++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL flush_miss: err %b want 0", bus_err); end
      cyc();
      flush  = 1'b0;
      PrWE   = 1'b0;
      PrRE   = 1'b1;
      PrAddr = 32'h0000_7F14;
      #1;
      cyc();
      flush = 1'b1;
      #1;
      n_cmp++; if (DEV_REQ !== 3'b010 || DEV_Addr !== 32'd4) begin n_err++; $display("FAIL flush_wait_req: req %b addr %h want 010 4", DEV_REQ, DEV_Addr); end
      cyc();
      DEV_ACK = 3'b010;
      DEV_RD1 = 32'hCAFE_0001;
      #1;
      n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL flush_wait_stall: got %b want 1", stall); end
      cyc();
      DEV_ACK = 3'b000;
      #1;
      n_cmp++; if (PrRD !== 32'hCAFE_0001 || stall !== 1'b0) begin n_err++; $display("FAIL flush_complete: rd %h stall %b want cafe0001 0", PrRD, stall); end
      flush = 1'b0;
      PrRE  = 1'b0;
      cyc();
      $display("flush: wait transaction rd=%h", PrRD);
   endtask

   task automatic test_reset_mid();
      PrAddr  = 32'h0000_7F24;
      PrRE    = 1'b1;
      DEV_IRQ = 3'b111;
      #1;
      cyc();
      #1;
      n_cmp++; if (DEV_REQ !== 3'b100 || HWInt !== 6'b000111) begin n_err++; $display("FAIL rstmid_pre: req %b hwint %b want 100 000111", DEV_REQ, HWInt); end
      reset = 1'b1;
      PrRE  = 1'b0;
      cyc();
      #1;
      n_cmp++; if (DEV_REQ !== 3'b000 || stall !== 1'b0 || bus_err !== 1'b0) begin n_err++; $display("FAIL rstmid_ctl: req %b stall %b err %b want 000 0 0", DEV_REQ, stall, bus_err); end
      n_cmp++; if (PrRD !== 32'd0 || HWInt !== 6'd0) begin n_err++; $display("FAIL rstmid_data: rd %h hwint %b want 0 0", PrRD, HWInt); end
      n_cmp++; if (DEV_Addr !== 32'd0 || DEV_BE !== 4'd0) begin n_err++; $display("FAIL rstmid_latch: addr %h be %b want 0 0", DEV_Addr, DEV_BE); end
      reset   = 1'b0;
      DEV_IRQ = 3'b000;
      cyc();
      cyc();
      $display("reset during wait: outputs cleared");
   endtask

   task automatic test_irq();
      DEV_IRQ = 3'b010;
      #1;
      n_cmp++; if (HWInt !== 6'b000000) begin n_err++; $display("FAIL irq_latency: got %b want 000000", HWInt); end
      cyc();
      #1;
      n_cmp++; if (HWInt !== 6'b000010) begin n_err++; $display("FAIL irq_dev: got %b want 000010", HWInt); end
      EXT_IRQ = 3'b101;
      cyc();
      #1;
      n_cmp++; if (HWInt !== 6'b101010) begin n_err++; $display("FAIL irq_ext: got %b want 101010", HWInt); end
      DEV_IRQ = 3'b000;
      EXT_IRQ = 3'b000;
      cyc();
      #1;
      n_cmp++; if (HWInt !== 6'b000000) begin n_err++; $display("FAIL irq_clear: got %b want 000000", HWInt); end
      $display("irq: hwint sequence checked");
   endtask

   initial begin
      reset   = 1'b1;
      PrAddr  = '0;
      PrWD    = '0;
      PrBE    = '0;
      PrWE    = 1'b0;
      PrRE    = 1'b0;
      flush   = 1'b0;
      DEV_ACK = '0;
      DEV_RD0 = '0;
      DEV_RD1 = '0;
      DEV_RD2 = '0;
      DEV_IRQ = '0;
      EXT_IRQ = '0;
      #1;
      test_reset();
      test_load_t0();
      test_timeout();
      test_ack_at_timeout();
      test_miss();
      test_window_edges();
      test_store_ext();
      test_flush();
      test_reset_mid();
      test_irq();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
